// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package   : alu_pkg
// Purpose   : Shared types and constants for the ALU datapath blocks.
//             - state_e : control state of the multi-cycle adder/subtractor
//             - OP_ADD / OP_SUB : encoding of the op_sub select input
// Revision  : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/addsub_multicycle_addr_slice.sv
`default_nettype none
// ============================================================================
// Module    : addr_slice
// Purpose   : Combinational CHUNK-bit ripple-carry adder, one slice of the
//             multi-cycle adder/subtractor.
// Ports     : in1[CHUNK]   addend slice
//             in2[CHUNK]   addend slice (already inverted for subtract)
//             carry_in     carry into bit 0
//             sum[CHUNK]   slice sum
//             carry_out    carry out of the slice MSB
// Revision  : 1.0 - initial release
// ============================================================================
module addr_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] in1,
  input  logic [CHUNK-1:0] in2,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  logic [CHUNK:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]       = in1[i] ^ in2[i] ^ carry[i];
    assign carry[i + 1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
  end

  assign carry_out = carry[CHUNK];

endmodule
`default_nettype wire

// File: rtl/addsub_multicycle.sv
`default_nettype none
// ============================================================================
// Module    : addsub_multicycle
// Purpose   : WIDTH-bit adder/subtractor that processes CHUNK bits per clock,
//             rippling the carry through a register, wrapped in a
//             start/busy/done handshake. Flags are registered at completion.
// Ports     : clk, rst_n (async, active-low)
//             start    request, sampled only while idle
//             op_sub   0: a+b+cin   1: a-b (cin ignored)
//             a, b     operands, captured on accepted start
//             cin      carry-in for add
//             busy     operation in flight
//             done     one-cycle completion pulse
//             sum      result
//             cout     carry out of MSB (subtract: 1 = no borrow)
//             ovf      signed overflow
//             zero     sum == 0
// Revision  : 1.0 - initial release
// ============================================================================
module addsub_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTEP  = WIDTH / CHUNK;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;          // b already inverted for subtract
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic [CHUNK-1:0]  slice_sum;
  logic              slice_cout;

  // Select the operand slice addressed by the step counter.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NSTEP; k++) begin
      if (step_q == STEP_W'(k)) begin
        slice_a = a_q[k*CHUNK +: CHUNK];
        slice_b = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  addr_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .in1      (slice_a),
    .in2      (slice_b),
    .carry_in (carry_q),
    .sum      (slice_sum),
    .carry_out(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    step_d  = step_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtract is a + ~b + 1: invert b once here, seed carry with 1.
          b_d     = (op_sub == OP_SUB) ? ~b : b;
          carry_d = (op_sub == OP_ADD) ? cin : 1'b1;
          step_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < NSTEP; k++) begin
          if (step_q == STEP_W'(k)) begin
            work_d[k*CHUNK +: CHUNK] = slice_sum;
          end
        end
        carry_d = slice_cout;

        if (step_q == LAST_STEP) begin
          // work_d already holds the final slice, so flags see the full sum.
          sum_d   = work_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (work_d[MSB] != a_q[MSB]);
          zero_d  = (work_d == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      step_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_multicycle.sv
`default_nettype none
// ============================================================================
// Module    : tb_addsub_multicycle
// Purpose   : Self-checking bench for addsub_multicycle with three parameter
//             sets (8/2, 4/4, 16/1) against a plain-arithmetic model.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_addsub_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic op_sub;
  logic cin;

  logic        start8, busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;
  logic        start4, busy4, done4, cout4, ovf4, zero4;
  logic [3:0]  a4, b4, sum4;
  logic        start16, busy16, done16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_multicycle #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_sub(op_sub), .a(a8), .b(b8),
    .cin(cin), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .ovf(ovf8), .zero(zero8)
  );

  addsub_multicycle #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op_sub), .a(a4), .b(b4),
    .cin(cin), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .zero(zero4)
  );

  addsub_multicycle #(.WIDTH(16), .CHUNK(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op_sub(op_sub), .a(a16), .b(b16),
    .cin(cin), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .ovf(ovf16), .zero(zero16)
  );

  // Reference: integer arithmetic. Packed as {cout, ovf, zero, sum[7:0]}.
  function automatic logic [10:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic sub);
    int ux, uy, sx, sy, ci, ur, sr;
    logic [7:0] s;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (sub) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + ci;
      sr = sx + sy + ci;
      co = (ur > 255);
    end
    s  = ur[7:0];
    ov = (sr > 127) || (sr < -128);
    return {co, ov, (s == 8'h00), s};
  endfunction

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic sub, input logic [10:0] exp_res, input string nm);
    int lat;
    @(negedge clk);
    a8 = x; b8 = y; cin = c; op_sub = sub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      n_tests++;
      if (busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy: got %b need 1 (cycle %0d)", nm, busy8, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d need 4", nm, lat);
    end
    n_tests++;
    if ({cout8, ovf8, zero8, sum8} !== exp_res) begin
      n_fail++;
      $display("FAIL %s result {cout,ovf,zero,sum}: got %b_%b_%b_%h need %b_%b_%b_%h",
               nm, cout8, ovf8, zero8, sum8, exp_res[10], exp_res[9], exp_res[8], exp_res[7:0]);
    end
    n_tests++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_with_done: got %b need 0", nm, busy8);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got %b need 0", nm, done8);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy8, done8, sum8, cout8, ovf8, zero8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b need all 0",
               busy8, done8, sum8, cout8, ovf8, zero8);
    end
    n_tests++;
    if ({busy4, done4, sum4, cout4, ovf4, zero4, busy16, done16, sum16, cout16, ovf16, zero16} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_sweep: got sum4=%h sum16=%h busy4=%b busy16=%b need 0", sum4, sum16, busy4, busy16);
    end
  endtask

  task automatic test_add();
    run8(8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 8'h01}, "add_0_0_cin");
    run8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 8'h80}, "add_7f_01");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00}, "add_ff_01");
  endtask

  task automatic test_sub();
    run8(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE}, "sub_05_07");
    run8(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE}, "sub_05_07_cin1");
    run8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 8'h7F}, "sub_80_01");
    run8(8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 8'h7F}, "sub_80_01_cin1");
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    logic c, s;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      s = 1'($urandom);
      run8(x, y, c, s, ref8(x, y, c, s), "random");
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin = 1'b0; op_sub = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; op_sub = 1'b1; cin = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 2;
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL ignore_start latency: got %0d need 4", lat);
    end
    n_tests++;
    if ({cout8, ovf8, zero8, sum8} !== {1'b0, 1'b0, 1'b0, 8'h33}) begin
      n_fail++;
      $display("FAIL ignore_start result: got sum=%h cout=%b ovf=%b zero=%b need sum=33 cout=0 ovf=0 zero=0",
               sum8, cout8, ovf8, zero8);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_start extra_op: got done=%b busy=%b need 0 0", done8, busy8);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin = 1'b0; op_sub = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 4 || sum8 !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b first: got lat=%0d sum=%h need lat=4 sum=30", lat, sum8);
    end
    // Raise start inside the done cycle; the next edge must accept it.
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      n_tests++;
      if (sum8 !== 8'h30 || busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b hold: got sum=%h busy=%b need sum=30 busy=1", sum8, busy8);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 4 || sum8 !== 8'h03) begin
      n_fail++;
      $display("FAIL b2b second: got lat=%0d sum=%h need lat=4 sum=03", lat, sum8);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin = 1'b1; op_sub = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy8, done8, sum8, cout8, ovf8, zero8} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset immediate: got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b need all 0",
               busy8, done8, sum8, cout8, ovf8, zero8);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset held: got done=%b busy=%b need 0 0", done8, busy8);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({busy8, done8, sum8} !== 10'h000) begin
        n_fail++;
        $display("FAIL async_reset abandoned: got busy=%b done=%b sum=%h need 0 0 00", busy8, done8, sum8);
      end
    end
    run8(8'h12, 8'h34, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 8'h46}, "after_reset");
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [6:0] exp_res, input string nm);
    int lat;
    @(negedge clk);
    a4 = x; b4 = y; cin = 1'b0; op_sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 1 || {cout4, ovf4, zero4, sum4} !== exp_res) begin
      n_fail++;
      $display("FAIL %s: got lat=%0d {cout,ovf,zero,sum}=%b need lat=1 %b",
               nm, lat, {cout4, ovf4, zero4, sum4}, exp_res);
    end
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic sub,
                       input logic [18:0] exp_res, input string nm);
    int lat;
    @(negedge clk);
    a16 = x; b16 = y; cin = 1'b0; op_sub = sub; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 16 || {cout16, ovf16, zero16, sum16} !== exp_res) begin
      n_fail++;
      $display("FAIL %s: got lat=%0d {cout,ovf,zero,sum}=%b_%b_%b_%h need lat=16 %b_%b_%b_%h",
               nm, lat, cout16, ovf16, zero16, sum16, exp_res[18], exp_res[17], exp_res[16], exp_res[15:0]);
    end
  endtask

  task automatic test_sweep();
    run4(4'hF, 4'h1, {1'b1, 1'b0, 1'b1, 4'h0}, "w4_f_1");
    run4(4'h7, 4'h1, {1'b0, 1'b1, 1'b0, 4'h8}, "w4_7_1");
    run16(16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}, "w16_ffff_1");
    run16(16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF}, "w16_sub_8000_1");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    op_sub  = 1'b0;
    cin     = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0;
    start4  = 1'b0; a4  = '0; b4  = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;

    test_add();
    test_sub();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_sweep();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_multicycle.md
# addsub_multicycle

Parametrised multi-cycle adder/subtractor for the ALU datapath, the successor to the fixed 2-bit full adders. It processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, rippling the carry through a register. A start/busy/done handshake wraps the operation. Results are registered signed/unsigned flags that feed the ALU flag logic.

## Interface
- WIDTH, 8: operand/result width; must be a multiple of CHUNK, ≥ 2.
- CHUNK, 2: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op_sub  in  1  0 = a+b+cin, 1 = a−b (cin ignored).
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- cin  in  1  carry-in for add, captured on accepted start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; results valid from this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- NSTEP = WIDTH/CHUNK. Two states: IDLE, RUN.
- IDLE: when start=1, latch a, b_eff = op_sub ? ~b : b, carry_reg = op_sub ? 1 : cin; step = 0; go to RUN.
- RUN: each cycle, add slice [step*CHUNK +: CHUNK] of a and b_eff with carry_reg. Write the slice into a working register and update carry_reg.
  - If step == NSTEP−1: load sum, cout, ovf, zero from working values; pulse done; return to IDLE.
  - Else step++.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- zero is computed on the full final sum.
- sum/cout/ovf/zero change only on completion and hold until the next completion. Intermediate slices are never visible.
- start while busy is ignored. Operands are not re-sampled during RUN.
- Reset (any time, including mid-RUN): state = IDLE, all outputs 0, working and carry registers 0, in-flight operation abandoned, no done.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0.
- Edge E0 samples start. busy=1 from E0 through the cycle before EN.
- Slices are processed at edges E1..EN, N = NSTEP.
- After EN: done=1 for exactly one cycle, busy=0, results valid.
- Latency is NSTEP cycles from the accepting edge. Defaults give 4.
- Back-to-back: start high during the done cycle is accepted (state is IDLE). Throughput is one operation per NSTEP cycles.
- CHUNK = WIDTH: NSTEP = 1; done one cycle after accept.
- done and busy are never high together.

## Structure
- Shared package alu_pkg:
  - state enum (IDLE, RUN);
  - op encoding constants (OP_ADD = 0, OP_SUB = 1).
- Sub-module addr_slice: combinational CHUNK-bit ripple adder with ports in1, in2, carry_in, sum, carry_out. It is instantiated once; the slice is selected by step.
- Step counter width: $clog2(NSTEP), minimum 1.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 unless noted.
- Add 0x00 + 0x00, cin=1 → sum=0x01, cout=0, ovf=0, zero=0. done exactly 4 cycles after the accept edge; busy high for those cycles.
- Add 0x7F + 0x01, cin=0 → 0x80, ovf=1, cout=0. Then 0xFF + 0x01 → 0x00, cout=1, zero=1, ovf=0.
- Subtract 0x05 − 0x07 → 0xFE, cout=0, ovf=0. Then 0x80 − 0x01 → 0x7F, cout=1, ovf=1. Toggling cin has no effect.
- Handshake:
  - Pulse start mid-RUN with other operands → ignored; the first result is unchanged.
  - Start held during the done cycle → second op accepted; its done arrives 4 cycles later.
  - sum holds its previous value while the second op runs.
- Drop rst_n asynchronously at step 2 → all outputs 0 immediately, no done. After release, 0x12 + 0x34 → 0x46 with normal latency.
- Parameter sweep WIDTH=4/CHUNK=4 and WIDTH=16/CHUNK=1:
  - 0xF + 0x1 → 0x0, cout=1, done after 1 cycle.
  - 0xFFFF + 0x0001 → 0x0000, cout=1, done after 16 cycles.
